rs232_bus_arbiter: RTL and testbench

- Two-master arbiter in front of the Rs232 memory-mapped peripheral. It lets two requesters (CPU core and DMA/debug master) share the single RS232 data port.
- Decodes requests aimed at the RS232 data address and grants the port round-robin.
- Forwards one transaction at a time using the peripheral's read_q/write_q -> read_dn/write_dn handshake.
- Halts the losing master and aborts hung transactions via a timeout.

---
 rtl/rs232_bus_arbiter_if.sv | 61 ++++++
 rtl/rs232_bus_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_rs232_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_bus_arbiter_if.sv
// Purpose : bundles both master request ports, the RS232 peripheral port and arbiter status.
// Latency : wires only; timing is set by the arbiter driving the slave modport.
// Backpress: masters are stalled through mX_halt. The peripheral stalls through s_rw_halt.
// Ports   : m0_*/m1_* are master-side request/response, s_* connect to the Rs232 block,
//           timeout_cnt/grant are status. The slave modport is the arbiter view and the
//           master modport is the environment view.
interface rs232_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] m0_addr_in;
  logic [DATA_W-1:0] m0_data_in;
  logic              m0_read_q;
  logic              m0_write_q;
  logic [DATA_W-1:0] m0_data_out;
  logic              m0_read_dn;
  logic              m0_write_dn;
  logic              m0_halt;

  logic [ADDR_W-1:0] m1_addr_in;
  logic [DATA_W-1:0] m1_data_in;
  logic              m1_read_q;
  logic              m1_write_q;
  logic [DATA_W-1:0] m1_data_out;
  logic              m1_read_dn;
  logic              m1_write_dn;
  logic              m1_halt;

  logic [ADDR_W-1:0] s_addr_out;
  logic [DATA_W-1:0] s_data_out;
  logic              s_read_q;
  logic              s_write_q;
  logic              s_halt_q;
  logic [DATA_W-1:0] s_data_in;
  logic              s_read_dn;
  logic              s_write_dn;
  logic              s_rw_halt;

  logic [7:0]        timeout_cnt;
  logic [1:0]        grant;

  modport master (
    output m0_addr_in, m0_data_in, m0_read_q, m0_write_q,
    input  m0_data_out, m0_read_dn, m0_write_dn, m0_halt,
    output m1_addr_in, m1_data_in, m1_read_q, m1_write_q,
    input  m1_data_out, m1_read_dn, m1_write_dn, m1_halt,
    input  s_addr_out, s_data_out, s_read_q, s_write_q, s_halt_q,
    output s_data_in, s_read_dn, s_write_dn, s_rw_halt,
    input  timeout_cnt, grant
  );

  modport slave (
    input  m0_addr_in, m0_data_in, m0_read_q, m0_write_q,
    output m0_data_out, m0_read_dn, m0_write_dn, m0_halt,
    input  m1_addr_in, m1_data_in, m1_read_q, m1_write_q,
    output m1_data_out, m1_read_dn, m1_write_dn, m1_halt,
    output s_addr_out, s_data_out, s_read_q, s_write_q, s_halt_q,
    input  s_data_in, s_read_dn, s_write_dn, s_rw_halt,
    output timeout_cnt, grant
  );
endinterface

// File: rtl/rs232_bus_arbiter.sv
// Purpose : round-robin two-master arbiter in front of the Rs232 data register, with a hung-transaction timeout.
// Latency : s_*_q rises 1 cycle after a request is first seen. mX_*_dn pulses 1 cycle after slave done or abort.
// Backpress: a requesting non-owner is held on mX_halt. The owner is halted while BUSY or while s_rw_halt is high.
// Ports   : clk, rst (async active-low). bus is the slave modport of rs232_bus_arbiter_if and carries
//           the m0/m1 master ports, the s_* peripheral port, timeout_cnt and the one-hot grant.
`ifndef RS232_DATA_ADDR
`define RS232_DATA_ADDR 32'h0000_F000
`endif

module rs232_bus_arbiter #(
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       DATA_W          = 32,
  parameter logic [ADDR_W-1:0] RS232_DATA_ADDR = `RS232_DATA_ADDR,
  parameter int unsigned       TIMEOUT_CYC     = 65535,
  parameter logic [DATA_W-1:0] ERR_DATA        = {DATA_W{1'b1}}
) (
  input logic                clk,
  input logic                rst,
  rs232_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_data_q, lat_data_d;
  logic              lat_wr_q, lat_wr_d;
  logic [15:0]       timer_q, timer_d;
  logic [7:0]        timeout_cnt_q, timeout_cnt_d;
  logic [DATA_W-1:0] m0_data_q, m0_data_d;
  logic [DATA_W-1:0] m1_data_q, m1_data_d;
  logic              m0_rdn_q, m0_rdn_d;
  logic              m0_wdn_q, m0_wdn_d;
  logic              m1_rdn_q, m1_rdn_d;
  logic              m1_wdn_q, m1_wdn_d;

  logic v0, v1;
  logic owner;
  logic owner_req;
  logic done;
  logic win_vld, win;
  logic resp_vld;
  logic [DATA_W-1:0] resp_data;
  logic halt0, halt1;

  // Only requests decoded to the RS232 data register take part in arbitration.
  assign v0 = (bus.m0_read_q | bus.m0_write_q) && (bus.m0_addr_in == RS232_DATA_ADDR);
  assign v1 = (bus.m1_read_q | bus.m1_write_q) && (bus.m1_addr_in == RS232_DATA_ADDR);

  assign owner     = grant_q[1];
  assign owner_req = owner ? (bus.m1_read_q | bus.m1_write_q) : (bus.m0_read_q | bus.m0_write_q);
  assign done      = bus.s_read_dn | bus.s_write_dn;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    lat_addr_d    = lat_addr_q;
    lat_data_d    = lat_data_q;
    lat_wr_d      = lat_wr_q;
    timer_d       = timer_q;
    timeout_cnt_d = timeout_cnt_q;
    m0_data_d     = m0_data_q;
    m1_data_d     = m1_data_q;
    m0_rdn_d      = 1'b0;
    m0_wdn_d      = 1'b0;
    m1_rdn_d      = 1'b0;
    m1_wdn_d      = 1'b0;
    win_vld       = 1'b0;
    win           = 1'b0;
    resp_vld      = 1'b0;
    resp_data     = ERR_DATA;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rr_ptr_q) begin
          if (v0)      begin win_vld = 1'b1; win = 1'b0; end
          else if (v1) begin win_vld = 1'b1; win = 1'b1; end
        end else begin
          if (v1)      begin win_vld = 1'b1; win = 1'b1; end
          else if (v0) begin win_vld = 1'b1; win = 1'b0; end
        end
        if (win_vld) begin
          // read_q and write_q together resolve to a write.
          lat_addr_d = win ? bus.m1_addr_in : bus.m0_addr_in;
          lat_data_d = win ? bus.m1_data_in : bus.m0_data_in;
          lat_wr_d   = win ? bus.m1_write_q : bus.m0_write_q;
          grant_d    = win ? 2'b10 : 2'b01;
          state_d    = BUSY;
        end
      end

      BUSY: begin
        timer_d = timer_q + 16'd1;
        // A done on the threshold cycle wins over the timeout.
        if (done || (timer_q == TIMER_LAST)) begin
          resp_vld  = 1'b1;
          resp_data = done ? bus.s_data_in : ERR_DATA;
          timer_d   = '0;
          state_d   = RELEASE;
          if (!done && (timeout_cnt_q != 8'hFF)) begin
            timeout_cnt_d = timeout_cnt_q + 8'd1;
          end
        end
        if (resp_vld) begin
          if (owner) begin
            m1_wdn_d = lat_wr_q;
            m1_rdn_d = !lat_wr_q;
            if (!lat_wr_q) m1_data_d = resp_data;
          end else begin
            m0_wdn_d = lat_wr_q;
            m0_rdn_d = !lat_wr_q;
            if (!lat_wr_q) m0_data_d = resp_data;
          end
        end
      end

      RELEASE: begin
        // Hold here until the owner drops its request so that it is not re-served by a stale level.
        if (!owner_req) begin
          rr_ptr_d = !owner;
          grant_d  = 2'b00;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= 1'b0;
      grant_q       <= 2'b00;
      lat_addr_q    <= '0;
      lat_data_q    <= '0;
      lat_wr_q      <= 1'b0;
      timer_q       <= '0;
      timeout_cnt_q <= '0;
      m0_data_q     <= '0;
      m1_data_q     <= '0;
      m0_rdn_q      <= 1'b0;
      m0_wdn_q      <= 1'b0;
      m1_rdn_q      <= 1'b0;
      m1_wdn_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      lat_addr_q    <= lat_addr_d;
      lat_data_q    <= lat_data_d;
      lat_wr_q      <= lat_wr_d;
      timer_q       <= timer_d;
      timeout_cnt_q <= timeout_cnt_d;
      m0_data_q     <= m0_data_d;
      m1_data_q     <= m1_data_d;
      m0_rdn_q      <= m0_rdn_d;
      m0_wdn_q      <= m0_wdn_d;
      m1_rdn_q      <= m1_rdn_d;
      m1_wdn_q      <= m1_wdn_d;
    end
  end

  // The owner is stalled until its done pulse. Non-owners are stalled only if they target the port.
  // Gating with rst keeps every output low while reset is held.
  always_comb begin
    halt0 = 1'b0;
    halt1 = 1'b0;
    if (grant_q[0]) halt0 = ((state_q == BUSY) | bus.s_rw_halt) & ~(m0_rdn_q | m0_wdn_q);
    else            halt0 = v0;
    if (grant_q[1]) halt1 = ((state_q == BUSY) | bus.s_rw_halt) & ~(m1_rdn_q | m1_wdn_q);
    else            halt1 = v1;
    halt0 = halt0 & rst;
    halt1 = halt1 & rst;
  end

  assign bus.m0_data_out = m0_data_q;
  assign bus.m0_read_dn  = m0_rdn_q;
  assign bus.m0_write_dn = m0_wdn_q;
  assign bus.m0_halt     = halt0;
  assign bus.m1_data_out = m1_data_q;
  assign bus.m1_read_dn  = m1_rdn_q;
  assign bus.m1_write_dn = m1_wdn_q;
  assign bus.m1_halt     = halt1;

  assign bus.s_addr_out  = lat_addr_q;
  assign bus.s_data_out  = lat_data_q;
  assign bus.s_read_q    = (state_q == BUSY) & ~lat_wr_q;
  assign bus.s_write_q   = (state_q == BUSY) & lat_wr_q;
  assign bus.s_halt_q    = (state_q == BUSY);

  assign bus.timeout_cnt = timeout_cnt_q;
  assign bus.grant       = grant_q;

endmodule

// File: tb/tb_rs232_bus_arbiter.sv
// Purpose : directed self-checking bench for rs232_bus_arbiter, with the timeout shortened to 16 cycles.
// Latency : inputs change 1 time unit after the rising edge and outputs are sampled there.
// Backpress: the bench plays both masters and the Rs232 peripheral.
module tb_rs232_bus_arbiter;

  localparam logic [31:0] ADDR = 32'h0000_F000;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  rs232_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rs232_bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .RS232_DATA_ADDR(ADDR),
    .TIMEOUT_CYC(16),
    .ERR_DATA(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.m0_addr_in = '0; bus.m0_data_in = '0; bus.m0_read_q = 1'b0; bus.m0_write_q = 1'b0;
    bus.m1_addr_in = '0; bus.m1_data_in = '0; bus.m1_read_q = 1'b0; bus.m1_write_q = 1'b0;
    bus.s_data_in = '0; bus.s_read_dn = 1'b0; bus.s_write_dn = 1'b0; bus.s_rw_halt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    clear_inputs();
    step();
    step();
    chk("rst_grant", bus.grant, 0);
    chk("rst_s_read_q", bus.s_read_q, 0);
    chk("rst_s_write_q", bus.s_write_q, 0);
    chk("rst_s_halt_q", bus.s_halt_q, 0);
    chk("rst_timeout_cnt", bus.timeout_cnt, 0);
    chk("rst_m0_data_out", bus.m0_data_out, 0);
    rst = 1'b1;

    // m0 writes 0x41, the peripheral answers in cycle 4.
    bus.m0_addr_in = ADDR; bus.m0_data_in = 32'h41; bus.m0_write_q = 1'b1;
    #1;
    chk("s1_c0_m0_halt", bus.m0_halt, 1);
    chk("s1_c0_s_write_q", bus.s_write_q, 0);
    step();
    chk("s1_c1_grant", bus.grant, 2'b01);
    chk("s1_c1_s_write_q", bus.s_write_q, 1);
    chk("s1_c1_s_read_q", bus.s_read_q, 0);
    chk("s1_c1_s_data_out", bus.s_data_out, 32'h41);
    chk("s1_c1_s_addr_out", bus.s_addr_out, ADDR);
    chk("s1_c1_s_halt_q", bus.s_halt_q, 1);
    chk("s1_c1_m0_halt", bus.m0_halt, 1);
    chk("s1_c1_m1_halt", bus.m1_halt, 0);
    step();
    chk("s1_c2_s_write_q", bus.s_write_q, 1);
    step();
    step();
    chk("s1_c4_s_write_q", bus.s_write_q, 1);
    chk("s1_c4_m0_write_dn", bus.m0_write_dn, 0);
    bus.s_write_dn = 1'b1;
    step();
    bus.s_write_dn = 1'b0;
    bus.m0_write_q = 1'b0;
    chk("s1_c5_m0_write_dn", bus.m0_write_dn, 1);
    chk("s1_c5_s_write_q", bus.s_write_q, 0);
    chk("s1_c5_s_halt_q", bus.s_halt_q, 0);
    chk("s1_c5_m0_halt", bus.m0_halt, 0);
    chk("s1_c5_m1_halt", bus.m1_halt, 0);
    chk("s1_c5_m0_read_dn", bus.m0_read_dn, 0);
    chk("s1_c5_m0_data_out", bus.m0_data_out, 0);
    step();
    chk("s1_c6_m0_write_dn", bus.m0_write_dn, 0);
    chk("s1_c6_grant", bus.grant, 2'b00);

    // Reset returns rr_ptr to 0, then both masters read at once.
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.m0_addr_in = ADDR; bus.m0_read_q = 1'b1;
    bus.m1_addr_in = ADDR; bus.m1_read_q = 1'b1;
    #1;
    chk("s2_c0_m1_halt", bus.m1_halt, 1);
    step();
    chk("s2_c1_grant", bus.grant, 2'b01);
    chk("s2_c1_s_read_q", bus.s_read_q, 1);
    chk("s2_c1_m1_halt", bus.m1_halt, 1);
    bus.s_data_in = 32'h5A; bus.s_read_dn = 1'b1;
    step();
    bus.s_read_dn = 1'b0;
    chk("s2_c2_m0_read_dn", bus.m0_read_dn, 1);
    chk("s2_c2_m0_data_out", bus.m0_data_out, 32'h5A);
    chk("s2_c2_m0_halt", bus.m0_halt, 0);
    chk("s2_c2_m1_halt", bus.m1_halt, 1);
    chk("s2_c2_grant", bus.grant, 2'b01);
    step();
    chk("s2_c3_m0_read_dn", bus.m0_read_dn, 0);
    chk("s2_c3_grant_held", bus.grant, 2'b01);
    chk("s2_c3_m1_halt", bus.m1_halt, 1);
    chk("s2_c3_s_read_q", bus.s_read_q, 0);
    bus.m0_read_q = 1'b0;
    step();
    chk("s2_c4_grant", bus.grant, 2'b00);
    chk("s2_c4_m1_halt", bus.m1_halt, 1);
    step();
    chk("s2_c5_grant", bus.grant, 2'b10);
    chk("s2_c5_s_read_q", bus.s_read_q, 1);
    bus.s_data_in = 32'h33; bus.s_read_dn = 1'b1;
    step();
    bus.s_read_dn = 1'b0;
    bus.m1_read_q = 1'b0;
    chk("s2_c6_m1_read_dn", bus.m1_read_dn, 1);
    chk("s2_c6_m1_data_out", bus.m1_data_out, 32'h33);
    chk("s2_c6_m0_data_out", bus.m0_data_out, 32'h5A);
    step();
    chk("s2_c7_grant", bus.grant, 2'b00);

    // Both masters keep requesting: grants alternate starting from m0.
    bus.m0_read_q = 1'b1;
    bus.m1_read_q = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int w;
      w = 0;
      while (bus.grant == 2'b00 && w < 6) begin
        step();
        w++;
      end
      chk($sformatf("s3_grant_%0d", i), bus.grant, (i % 2 == 0) ? 2'b01 : 2'b10);
      bus.s_data_in = 32'(i); bus.s_read_dn = 1'b1;
      step();
      bus.s_read_dn = 1'b0;
      chk($sformatf("s3_read_dn_%0d", i), (i % 2 == 0) ? bus.m0_read_dn : bus.m1_read_dn, 1);
      if (i % 2 == 0) bus.m0_read_q = 1'b0; else bus.m1_read_q = 1'b0;
      step();
      if (i % 2 == 0) bus.m0_read_q = 1'b1; else bus.m1_read_q = 1'b1;
    end
    bus.m0_read_q = 1'b0;
    bus.m1_read_q = 1'b0;
    chk("s3_m0_data_out", bus.m0_data_out, 32'd2);
    chk("s3_m1_data_out", bus.m1_data_out, 32'd3);
    step();
    chk("s3_end_grant", bus.grant, 2'b00);

    // The peripheral never answers: abort after 16 BUSY cycles.
    bus.m0_addr_in = ADDR; bus.m0_read_q = 1'b1;
    step();
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("s4_c%0d_s_read_q", k), bus.s_read_q, 1);
      chk($sformatf("s4_c%0d_m0_read_dn", k), bus.m0_read_dn, 0);
      step();
    end
    chk("s4_c17_m0_read_dn", bus.m0_read_dn, 1);
    chk("s4_c17_m0_data_out", bus.m0_data_out, 32'hFFFF_FFFF);
    chk("s4_c17_timeout_cnt", bus.timeout_cnt, 1);
    chk("s4_c17_s_read_q", bus.s_read_q, 0);
    chk("s4_c17_m0_halt", bus.m0_halt, 0);
    bus.m0_read_q = 1'b0;
    step();
    chk("s4_c18_m0_read_dn", bus.m0_read_dn, 0);
    chk("s4_c18_grant", bus.grant, 2'b00);
    bus.m0_data_in = 32'h77; bus.m0_write_q = 1'b1;
    step();
    chk("s4_next_grant", bus.grant, 2'b01);
    chk("s4_next_s_write_q", bus.s_write_q, 1);
    chk("s4_next_s_data_out", bus.s_data_out, 32'h77);
    bus.s_write_dn = 1'b1;
    step();
    bus.s_write_dn = 1'b0;
    bus.m0_write_q = 1'b0;
    chk("s4_next_m0_write_dn", bus.m0_write_dn, 1);
    chk("s4_next_timeout_cnt", bus.timeout_cnt, 1);
    chk("s4_next_m0_data_out", bus.m0_data_out, 32'hFFFF_FFFF);
    step();

    // A request to a different address is ignored.
    bus.m1_addr_in = ADDR + 32'd1; bus.m1_read_q = 1'b1;
    #1;
    chk("s5_c0_m1_halt", bus.m1_halt, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("s5_c%0d_s_read_q", k), bus.s_read_q, 0);
      chk($sformatf("s5_c%0d_grant", k), bus.grant, 2'b00);
      chk($sformatf("s5_c%0d_m1_halt", k), bus.m1_halt, 0);
      chk($sformatf("s5_c%0d_m1_read_dn", k), bus.m1_read_dn, 0);
    end
    bus.m1_read_q = 1'b0;
    step();

    // Reset in the middle of BUSY. rr_ptr points at m1 before the reset.
    bus.m0_addr_in = ADDR; bus.m0_read_q = 1'b1;
    step();
    chk("s6_busy_s_read_q", bus.s_read_q, 1);
    chk("s6_busy_grant", bus.grant, 2'b01);
    #3;
    rst = 1'b0;
    #1;
    chk("s6_rst_s_read_q", bus.s_read_q, 0);
    chk("s6_rst_grant", bus.grant, 2'b00);
    chk("s6_rst_s_halt_q", bus.s_halt_q, 0);
    chk("s6_rst_m0_read_dn", bus.m0_read_dn, 0);
    chk("s6_rst_m1_read_dn", bus.m1_read_dn, 0);
    chk("s6_rst_m0_halt", bus.m0_halt, 0);
    chk("s6_rst_timeout_cnt", bus.timeout_cnt, 0);
    bus.m1_addr_in = ADDR; bus.m1_read_q = 1'b1;
    step();
    step();
    chk("s6_in_rst_grant", bus.grant, 2'b00);
    rst = 1'b1;
    step();
    chk("s6_after_grant", bus.grant, 2'b01);
    chk("s6_after_s_read_q", bus.s_read_q, 1);
    chk("s6_after_m1_halt", bus.m1_halt, 1);

    clear_inputs();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
